// File: rtl/mips_pkg.sv
// Shared types for the MIPS boot path: loader state encoding and word geometry.
package mips_pkg;
   localparam int WORD_BYTES = 4;
   localparam int INSTR_W    = 32;

   typedef enum logic [2:0] {
      LEN_HI,
      LEN_LO,
      DATA,
      CHECK,
      RUN,
      ERROR
   } load_state_t;
endpackage

// File: rtl/boot_loader_byte_assembler.sv
// Packs a byte stream into big-endian 32-bit words; word_valid pulses the cycle
// after the 4th byte, with the completed word on `word`.
module byte_assembler
   import mips_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               clear,
   input  logic [7:0]         in_byte,
   input  logic               strobe,
   output logic [INSTR_W-1:0] word,
   output logic               word_valid,
   output logic [1:0]         idx
);

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         word       <= '0;
         idx        <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= strobe && (idx == 2'(WORD_BYTES - 1));
         if (strobe) begin
            // first byte of a word ends up in [31:24] after four shifts
            word <= {word[INSTR_W-9:0], in_byte};
            idx  <= idx + 2'd1;
         end
      end
   end

endmodule

// File: rtl/boot_loader.sv
// Serial boot loader: header (16-bit word count), big-endian words written to
// imem from BASE_ADDR, then an XOR checksum byte that gates release of the core.
module boot_loader
   import mips_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    MAX_WORDS  = 256,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  reload,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [INSTR_W-1:0]    imem_wdata,
   output logic                  cpu_hold,
   output logic                  load_done,
   output logic                  load_error,
   output logic [15:0]           words_loaded
);

   load_state_t state, state_nxt;
   logic [15:0] count;
   logic [7:0]  csum;
   logic [1:0]  idx;
   logic        xfer, asm_strobe, last_byte;
   logic [15:0] hdr_count;

   assign in_ready   = (state == LEN_HI) || (state == LEN_LO) ||
                       (state == DATA)   || (state == CHECK);
   assign xfer       = in_valid && in_ready;
   assign asm_strobe = xfer && (state == DATA);
   assign hdr_count  = {count[15:8], in_data};
   assign last_byte  = (idx == 2'(WORD_BYTES - 1)) && (words_loaded == count - 16'd1);

   assign cpu_hold   = (state != RUN);
   assign load_done  = (state == RUN);
   assign load_error = (state == ERROR);

   byte_assembler u_asm (
      .clock      (clock),
      .reset      (reset),
      .clear      (reload),
      .in_byte    (in_data),
      .strobe     (asm_strobe),
      .word       (imem_wdata),
      .word_valid (imem_we),
      .idx        (idx)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         LEN_HI: if (xfer) state_nxt = LEN_LO;
         LEN_LO: if (xfer) begin
            if (hdr_count > 16'(MAX_WORDS)) state_nxt = ERROR;
            else if (hdr_count == 16'd0)     state_nxt = CHECK;
            else                             state_nxt = DATA;
         end
         DATA:   if (xfer && last_byte) state_nxt = CHECK;
         CHECK:  if (xfer) state_nxt = (in_data == csum) ? RUN : ERROR;
         default: state_nxt = state;
      endcase
   end

   // reload shares the reset path, so a byte arriving with it is dropped
   always_ff @(posedge clock) begin
      if (reset || reload) begin
         state        <= LEN_HI;
         count        <= '0;
         csum         <= '0;
         words_loaded <= '0;
         imem_addr    <= BASE_ADDR;
      end else begin
         state <= state_nxt;
         if (xfer && state == LEN_HI) count <= {in_data, 8'h00};
         if (xfer && state == LEN_LO) count <= hdr_count;
         if (asm_strobe) begin
            csum <= csum ^ in_data;
            if (idx == 2'(WORD_BYTES - 1)) words_loaded <= words_loaded + 16'd1;
         end
         // address advances after the write cycle so it is stable while imem_we is high
         if (imem_we) imem_addr <= imem_addr + ADDR_WIDTH'(WORD_BYTES);
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: fixed vector table, hand sequences for
// reload/reset/throughput, and randomized streams against a stream-level model.
module tb_boot_loader;

   localparam int MAXW = 256;

   logic        clock = 1'b0;
   logic        reset, reload, in_valid, in_ready;
   logic [7:0]  in_data;
   logic        imem_we, cpu_hold, load_done, load_error;
   logic [31:0] imem_addr, imem_wdata;
   logic [15:0] words_loaded;

   int n_pass  = 0;
   int n_total = 0;

   logic [7:0]  tx_q[$];
   logic [63:0] wr_q[$];
   logic [63:0] exp_q[$];

   boot_loader #(.ADDR_WIDTH(32), .MAX_WORDS(MAXW), .BASE_ADDR(32'h0)) dut (
      .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .load_done(load_done),
      .load_error(load_error), .words_loaded(words_loaded)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (imem_we) wr_q.push_back({imem_addr, imem_wdata});

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      wr_q.delete();
   endtask

   task automatic send_q(input int mingap, input int maxgap);
      int g;
      while (tx_q.size() > 0) begin
         g = $urandom_range(maxgap, mingap);
         if (g > 0) begin
            in_valid = 1'b0;
            repeat (g) @(posedge clock);
            #1;
         end
         in_data  = tx_q.pop_front();
         in_valid = 1'b1;
         @(posedge clock); #1;
      end
      in_valid = 1'b0;
   endtask

   // Stream-level reference: header count, words from consecutive byte groups, XOR of payload
   task automatic model(input logic [7:0] s[$], output logic done, output int words);
      logic [15:0] cnt;
      logic [7:0]  x;
      exp_q.delete();
      cnt = {s[0], s[1]};
      done = 1'b0;
      words = 0;
      if (cnt <= 16'(MAXW)) begin
         x = 8'h00;
         for (int w = 0; w < int'(cnt); w++) begin
            exp_q.push_back({32'(4 * w), s[2+4*w], s[3+4*w], s[4+4*w], s[5+4*w]});
            for (int k = 0; k < 4; k++) x ^= s[2+4*w+k];
         end
         done  = (s[2+4*cnt] == x);
         words = int'(cnt);
      end
   endtask

   task automatic check_end(input string name, input logic done, input int words);
      check({name, " nwr"}, 32'(wr_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
         check({name, " waddr"}, wr_q[i][63:32], exp_q[i][63:32]);
         check({name, " wdata"}, wr_q[i][31:0],  exp_q[i][31:0]);
      end
      check({name, " done"},  32'(load_done),    32'(done));
      check({name, " err"},   32'(load_error),   32'(!done));
      check({name, " hold"},  32'(cpu_hold),     32'(!done));
      check({name, " ready"}, 32'(in_ready),     32'd0);
      check({name, " words"}, 32'(words_loaded), 32'(words));
      wr_q.delete();
   endtask

   typedef struct {
      string       name;
      int          n;
      logic [95:0] b;
      logic        done;
      int          words;
      logic [31:0] w0, w1;
   } vec_t;

   vec_t vt[7];

   initial begin
      vec_t        v;
      logic [7:0]  s[$];
      logic [15:0] cnt;
      logic [7:0]  x, chk;
      logic        mdone;
      int          mwords;

      reset = 1'b1; reload = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (2) @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      check("rst hold",  32'(cpu_hold),     32'd1);
      check("rst ready", 32'(in_ready),     32'd1);
      check("rst we",    32'(imem_we),      32'd0);
      check("rst addr",  imem_addr,         32'h0);
      check("rst wdata", imem_wdata,        32'h0);
      check("rst done",  32'(load_done),    32'd0);
      check("rst err",   32'(load_error),   32'd0);
      check("rst words", 32'(words_loaded), 32'd0);

      // payload XOR of 20 08 00 05 01 09 50 20 is 8'h55
      vt[0] = '{"basic",   11, {8'h00,8'h02,8'h20,8'h08,8'h00,8'h05,8'h01,8'h09,8'h50,8'h20,8'h55,8'h00}, 1'b1, 2, 32'h2008_0005, 32'h0109_5020};
      vt[1] = '{"badck00", 11, {8'h00,8'h02,8'h20,8'h08,8'h00,8'h05,8'h01,8'h09,8'h50,8'h20,8'h00,8'h00}, 1'b0, 2, 32'h2008_0005, 32'h0109_5020};
      vt[2] = '{"badck5f", 11, {8'h00,8'h02,8'h20,8'h08,8'h00,8'h05,8'h01,8'h09,8'h50,8'h20,8'h5F,8'h00}, 1'b0, 2, 32'h2008_0005, 32'h0109_5020};
      vt[3] = '{"oversz",  2,  {8'h01,8'h01,80'h0}, 1'b0, 0, 32'h0, 32'h0};
      vt[4] = '{"empty",   3,  {8'h00,8'h00,8'h00,72'h0}, 1'b1, 0, 32'h0, 32'h0};
      vt[5] = '{"emptybad",3,  {8'h00,8'h00,8'h01,72'h0}, 1'b0, 0, 32'h0, 32'h0};
      vt[6] = '{"oneword", 7,  {8'h00,8'h01,8'hAA,8'hBB,8'hCC,8'hDD,8'h00,40'h0}, 1'b1, 1, 32'hAABB_CCDD, 32'h0};

      foreach (vt[t]) begin
         v = vt[t];
         do_reset();
         exp_q.delete();
         if (v.words > 0) exp_q.push_back({32'h0, v.w0});
         if (v.words > 1) exp_q.push_back({32'h4, v.w1});
         for (int i = 0; i < v.n; i++) tx_q.push_back(v.b[95-8*i -: 8]);
         send_q(0, t % 2);
         repeat (2) @(negedge clock);
         check_end(v.name, v.done, v.words);
      end

      // cpu_hold must fall exactly one cycle after the checksum transfer
      do_reset();
      tx_q = '{8'h00,8'h01,8'hAA,8'hBB,8'hCC,8'hDD};
      send_q(0, 0);
      @(negedge clock);
      check("hold pre ck", 32'(cpu_hold), 32'd1);
      tx_q = '{8'h00};
      send_q(0, 0);
      @(negedge clock);
      check("hold post ck", 32'(cpu_hold), 32'd0);

      // throughput: four back-to-back bytes give a single write
      do_reset();
      tx_q = '{8'h00,8'h01,8'hAA,8'hBB,8'hCC,8'hDD};
      send_q(0, 0);
      repeat (3) @(negedge clock);
      check("b2b nwr", 32'(wr_q.size()), 32'd1);
      if (wr_q.size() > 0) check("b2b data", wr_q[0][31:0], 32'hAABB_CCDD);

      // gapped bytes assemble the same word
      do_reset();
      tx_q = '{8'h00,8'h01,8'hAA,8'hBB,8'hCC,8'hDD};
      send_q(3, 3);
      repeat (3) @(negedge clock);
      check("gap nwr", 32'(wr_q.size()), 32'd1);
      if (wr_q.size() > 0) check("gap data", wr_q[0][31:0], 32'hAABB_CCDD);

      // exactly MAX_WORDS is accepted
      do_reset();
      tx_q = '{8'h01,8'h00};
      send_q(0, 0);
      @(negedge clock);
      check("max err",   32'(load_error), 32'd0);
      check("max ready", 32'(in_ready),   32'd1);

      // reload after 1.5 words, coincident with a valid byte
      do_reset();
      tx_q = '{8'h00,8'h02,8'h20,8'h08,8'h00,8'h05,8'h01,8'h09};
      send_q(0, 0);
      in_data = 8'h50; in_valid = 1'b1; reload = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0; reload = 1'b0;
      @(negedge clock);
      check("rld ready", 32'(in_ready),     32'd1);
      check("rld words", 32'(words_loaded), 32'd0);
      check("rld addr",  imem_addr,         32'h0);
      check("rld hold",  32'(cpu_hold),     32'd1);
      wr_q.delete();
      s = '{8'h00,8'h02,8'h20,8'h08,8'h00,8'h05,8'h01,8'h09,8'h50,8'h20,8'h55};
      model(s, mdone, mwords);
      tx_q = s;
      send_q(0, 1);
      repeat (2) @(negedge clock);
      check_end("rld reload", mdone, mwords);

      // reset while in RUN
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      check("runrst hold",  32'(cpu_hold),  32'd1);
      check("runrst done",  32'(load_done), 32'd0);
      check("runrst ready", 32'(in_ready),  32'd1);
      check("runrst addr",  imem_addr,      32'h0);

      // randomized streams; a trailing byte offered after the end must be ignored
      for (int it = 0; it < 25; it++) begin
         do_reset();
         cnt = ($urandom_range(7, 0) == 0) ? 16'($urandom_range(65535, MAXW + 1))
                                            : 16'($urandom_range(5, 0));
         s = '{cnt[15:8], cnt[7:0]};
         if (cnt <= 16'(MAXW)) begin
            x = 8'h00;
            for (int i = 0; i < 4 * int'(cnt); i++) begin
               s.push_back(8'($urandom));
               x ^= s[s.size()-1];
            end
            chk = ($urandom_range(3, 0) == 0) ? 8'($urandom) : x;
            s.push_back(chk);
         end
         model(s, mdone, mwords);
         tx_q = s;
         send_q(0, 2);
         in_data = 8'($urandom); in_valid = 1'b1;
         repeat (2) @(posedge clock);
         #1 in_valid = 1'b0;
         @(negedge clock);
         check_end($sformatf("rnd%0d", it), mdone, mwords);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
